// File: rtl/clock_pkg.sv
// Shared defaults and helpers for the CPU clock source.
// Derived constants assume a 50 MHz board oscillator.
package clock_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned RUN_HZ      = 100;
  localparam int unsigned DEBOUNCE_US = 1000;

  localparam int unsigned DIV_HALF        = CLK_HZ / (2 * RUN_HZ);
  localparam int unsigned DEBOUNCE_CYCLES = (CLK_HZ / 1_000_000) * DEBOUNCE_US;

  typedef enum logic {
    SRC_RUN    = 1'b0,
    SRC_MANUAL = 1'b1
  } clk_src_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_module_if.sv
// Board-side signals of the CPU clock source: button, mode switch and CPU clock.
interface clock_module_if;

  logic manual_clk;
  logic select;
  logic clk_out;

  modport master (
    output manual_clk,
    output select,
    input  clk_out
  );

  modport slave (
    input  manual_clk,
    input  select,
    output clk_out
  );

endinterface

// File: rtl/clock_module_debouncer.sv
// Push-button conditioner: 2-flop synchronizer followed by a stable-count filter.
// The level only changes after DEBOUNCE_CYCLES consecutive differing samples.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = clock_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  import clock_pkg::*;

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Any sample agreeing with the held level restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      level_q <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt     <= '0;
      level_q <= sync_q[1];
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign level = level_q;

endmodule

// File: rtl/clock_module.sv
// CPU clock source: free-running divided run clock or debounced push-button,
// selected by a synchronized switch and re-registered onto clk_out.
module clock_module #(
  parameter int unsigned DIV_HALF        = clock_pkg::DIV_HALF,
  parameter int unsigned DEBOUNCE_CYCLES = clock_pkg::DEBOUNCE_CYCLES
) (
  input  logic           clk,
  input  logic           rst_n,
  clock_module_if.slave  io
);
  import clock_pkg::*;

  localparam int unsigned DIV_W = cnt_width(DIV_HALF);

  logic [DIV_W-1:0] div_cnt;
  logic             div_q;
  logic [1:0]       sel_sync_q;
  logic             btn_db;
  logic             clk_out_q;
  clk_src_e         src;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (io.manual_clk),
    .level (btn_db)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_sync_q <= 2'b00;
    end else begin
      sel_sync_q <= {sel_sync_q[0], io.select};
    end
  end

  // Divider keeps running in manual mode so run mode resumes without a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      div_q   <= 1'b0;
    end else if (div_cnt == DIV_W'(DIV_HALF - 1)) begin
      div_cnt <= '0;
      div_q   <= ~div_q;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign src = clk_src_e'(sel_sync_q[1]);

  // Both mux inputs are flops, so the registered output cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_out_q <= 1'b0;
    end else begin
      clk_out_q <= (src == SRC_MANUAL) ? btn_db : div_q;
    end
  end

  assign io.clk_out = clk_out_q;

endmodule

// File: tb/tb_clock_module.sv
// Bench for clock_module with shortened divider/debounce parameters.
module tb_clock_module;

  localparam int unsigned DH = 5;
  localparam int unsigned DB = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  clock_module_if bus ();

  clock_module #(
    .DIV_HALF        (DH),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference: run clock from edge count, button level from a sliding window of samples.
  int unsigned m_edges;
  bit          m_db;
  bit          m_out;
  bit          m_sel [2];
  bit          m_hist [DB+1];

  always @(posedge clk or negedge rst_n) begin : ref_model
    bit all_diff;
    if (!rst_n) begin
      m_edges = 0;
      m_db    = 1'b0;
      m_out   = 1'b0;
      m_sel[0] = 1'b0;
      m_sel[1] = 1'b0;
      for (int k = 0; k <= DB; k++) m_hist[k] = 1'b0;
    end else begin
      m_edges++;
      m_out = m_sel[1] ? m_db : 1'(((m_edges - 1) / DH) % 2);
      all_diff = 1'b1;
      for (int k = 1; k <= DB; k++) if (m_hist[k] == m_db) all_diff = 1'b0;
      if (all_diff) m_db = !m_db;
      for (int k = DB; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = bus.manual_clk;
      m_sel[1]  = m_sel[0];
      m_sel[0]  = bus.select;
    end
  end

  bit pat_q [$];
  bit smp_q [$];
  int rises, falls, rise_at, width;

  task automatic run_pattern();
    smp_q.delete();
    foreach (pat_q[i]) begin
      @(negedge clk);
      bus.manual_clk = pat_q[i];
      @(posedge clk);
      #1;
      smp_q.push_back(bus.clk_out);
    end
  endtask

  task automatic analyze();
    bit prev = 1'b0;
    rises = 0; falls = 0; rise_at = -1; width = 0;
    foreach (smp_q[i]) begin
      if (smp_q[i] && !prev) begin
        rises++;
        if (rise_at < 0) rise_at = i;
      end
      if (!smp_q[i] && prev) falls++;
      if (smp_q[i] && rises == 1 && falls == 0) width++;
      prev = smp_q[i];
    end
  endtask

  task automatic test_reset();
    bit found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.clk_out === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL reset_pre_high: clk_out never rose, got %b want 1", bus.clk_out);
    end
    #3;
    rst_n = 1'b0;
    bus.select     = 1'($urandom);
    bus.manual_clk = 1'($urandom);
    #1;
    tests++;
    if (bus.clk_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: got %b want 0", bus.clk_out);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (bus.clk_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: got %b want 0", bus.clk_out);
    end
    bus.select     = 1'b0;
    bus.manual_clk = 1'b0;
    rst_n          = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      logic exp;
      @(posedge clk);
      #1;
      exp = (i == 6);
      tests++;
      if (bus.clk_out !== exp) begin
        fails++;
        $display("FAIL reset_first_rise edge %0d: got %b want %b", i, bus.clk_out, exp);
      end
    end
  endtask

  task automatic test_run_clock();
    int len = 0;
    int nruns = 0;
    bit seen = 1'b0;
    bus.select = 1'b0;
    pat_q.delete();
    for (int i = 0; i < 60; i++) pat_q.push_back(1'($urandom));
    run_pattern();
    for (int i = 1; i < smp_q.size(); i++) begin
      if (smp_q[i] != smp_q[i-1]) begin
        if (seen) begin
          nruns++;
          tests++;
          if (len != int'(DH)) begin
            fails++;
            $display("FAIL run_phase_len #%0d: got %0d want %0d", nruns, len, DH);
          end
        end
        seen = 1'b1;
        len  = 1;
      end else begin
        len++;
      end
    end
    tests++;
    if (nruns < 10) begin
      fails++;
      $display("FAIL run_phase_count: got %0d want >= 10", nruns);
    end
  endtask

  task automatic test_mode_switch();
    bit prev = 1'b1;
    bit found = 1'b0;
    bus.manual_clk = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.clk_out === 1'b1 && !prev) begin
        found = 1'b1;
        break;
      end
      prev = bus.clk_out;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL mode_switch_rise: no rise seen, got %b want 1", bus.clk_out);
    end
    @(posedge clk);
    @(negedge clk);
    bus.select = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      logic exp;
      @(posedge clk);
      #1;
      exp = (k < 3);
      tests++;
      if (bus.clk_out !== exp) begin
        fails++;
        $display("FAIL mode_switch edge %0d: got %b want %b", k, bus.clk_out, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    bus.select = 1'b1;
    repeat (5) @(negedge clk);
    pat_q.delete();
    for (int i = 0; i < 40; i++) pat_q.push_back(1'b1);
    for (int i = 0; i < 60; i++) pat_q.push_back(1'b0);
    run_pattern();
    analyze();
    tests++;
    if (rises != 1 || falls != 1) begin
      fails++;
      $display("FAIL clean_pulses: got rises=%0d falls=%0d want 1/1", rises, falls);
    end
    tests++;
    if (rise_at + 1 < 10 || rise_at + 1 > 12) begin
      fails++;
      $display("FAIL clean_latency: got %0d want 11+-1", rise_at + 1);
    end
    tests++;
    if (width < 39 || width > 41) begin
      fails++;
      $display("FAIL clean_width: got %0d want 40+-1", width);
    end
  endtask

  task automatic test_bounced_press();
    bit bounce_in  [10] = '{1,0,0,1,1,1,0,0,0,0};
    bit bounce_out [10] = '{0,0,0,0,1,1,1,0,0,1};
    pat_q.delete();
    foreach (bounce_in[i]) pat_q.push_back(bounce_in[i]);
    for (int i = 0; i < 40; i++) pat_q.push_back(1'b1);
    foreach (bounce_out[i]) pat_q.push_back(bounce_out[i]);
    for (int i = 0; i < 40; i++) pat_q.push_back(1'b0);
    run_pattern();
    analyze();
    tests++;
    if (rises != 1 || falls != 1) begin
      fails++;
      $display("FAIL bounce_edges: got rises=%0d falls=%0d want 1/1", rises, falls);
    end
    tests++;
    if (rise_at + 1 < 20 || rise_at + 1 > 22) begin
      fails++;
      $display("FAIL bounce_latency: got %0d want 21+-1", rise_at + 1);
    end
    tests++;
    if (width < 49 || width > 51) begin
      fails++;
      $display("FAIL bounce_width: got %0d want 50+-1", width);
    end
  endtask

  task automatic test_short_glitch();
    pat_q.delete();
    for (int i = 0; i < 5; i++) pat_q.push_back(1'b1);
    for (int i = 0; i < 30; i++) pat_q.push_back(1'b0);
    run_pattern();
    analyze();
    tests++;
    if (rises != 0 || falls != 0) begin
      fails++;
      $display("FAIL short_glitch: got rises=%0d falls=%0d want 0/0", rises, falls);
    end
  endtask

  task automatic test_random();
    int run = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      tests++;
      if (bus.clk_out !== m_out) begin
        fails++;
        $display("FAIL random cycle %0d: got %b want %b", i, bus.clk_out, m_out);
      end
      if (run == 0) begin
        bus.manual_clk = 1'($urandom_range(0, 1));
        run = int'($urandom_range(1, 14));
      end
      run--;
      if ($urandom_range(0, 39) == 0) bus.select = ~bus.select;
      if (i == 300) begin
        #3;
        rst_n = 1'b0;
      end
      if (i == 303) rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.select     = 1'b0;
    bus.manual_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_run_clock();
    test_mode_switch();
    test_clean_press();
    test_bounced_press();
    test_short_glitch();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
